tone_gain_meter: RTL

//  Measures the response of an amplifier stage under test from two sampled ADC channels:
//  the stage input (stimulus) and the stage output (response).
//  - Over a window of WINDOW valid samples, captures min/max per channel.
//  - Reports peak-to-peak amplitudes and a fixed-point log2 gain (output relative to input).
//  - Sits behind the ADC capture path; its results go to the sweep controller.

---
 rtl/tone_gain_meter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/tone_gain_meter.sv
// Windowed min/max capture on a stimulus/response ADC pair, reporting peak-to-peak
// amplitudes and a fixed-point log2 gain of the response relative to the stimulus.
module tone_gain_meter #(
  parameter int DW     = 12,
  parameter int WINDOW = 16,
  parameter int FRAC   = 3
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic                               continuous,
  input  logic                               abort,
  input  logic                               smp_valid,
  input  logic signed [DW-1:0]               in_smp,
  input  logic signed [DW-1:0]               out_smp,
  output logic                               res_valid,
  input  logic                               res_ready,
  output logic [DW:0]                        in_pp,
  output logic [DW:0]                        out_pp,
  output logic signed [$clog2(DW+1)+FRAC:0]  gain_l2,
  output logic                               in_zero,
  output logic                               busy,
  output logic                               overrun
);

  localparam int LW = $clog2(DW+1);
  localparam int CW = $clog2(WINDOW);

  typedef enum logic [1:0] {IDLE, ACC, LOG, DONE} state_t;

  state_t                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic signed [DW-1:0]      in_min_q, in_min_d, in_max_q, in_max_d;
  logic signed [DW-1:0]      out_min_q, out_min_d, out_max_q, out_max_d;
  logic [DW:0]               in_pp_q, in_pp_d, out_pp_q, out_pp_d;
  logic signed [LW+FRAC:0]   gain_q, gain_d;
  logic                      in_zero_q, in_zero_d;
  logic                      res_valid_q, res_valid_d;
  logic                      overrun_q, overrun_d;

  logic [DW:0]               in_pp_w, out_pp_w;
  logic signed [LW+FRAC:0]   gain_w;

  // {msb index, FRAC bits below the msb}; normalising the msb to bit DW zero-pads short values.
  function automatic logic [LW+FRAC-1:0] log2q(input logic [DW:0] x);
    logic [LW-1:0] msb;
    logic [DW:0]   norm;
    msb = '0;
    for (int i = 0; i <= DW; i++) begin
      if (x[i]) msb = LW'(i);
    end
    norm = x << (LW'(DW) - msb);
    return {msb, FRAC'(norm >> (DW - FRAC))};
  endfunction

  // Sign-extend before subtracting so full-scale swings fit without overflow.
  assign in_pp_w  = {in_max_q[DW-1], in_max_q} - {in_min_q[DW-1], in_min_q};
  assign out_pp_w = {out_max_q[DW-1], out_max_q} - {out_min_q[DW-1], out_min_q};
  assign gain_w   = (in_pp_w == '0) ? '0
                  : $signed({1'b0, log2q(out_pp_w)}) - $signed({1'b0, log2q(in_pp_w)});

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    in_min_d    = in_min_q;
    in_max_d    = in_max_q;
    out_min_d   = out_min_q;
    out_max_d   = out_max_q;
    in_pp_d     = in_pp_q;
    out_pp_d    = out_pp_q;
    gain_d      = gain_q;
    in_zero_d   = in_zero_q;
    res_valid_d = res_valid_q;
    overrun_d   = overrun_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACC;
          cnt_d   = '0;
        end
      end
      ACC: begin
        if (smp_valid) begin
          if (cnt_q == '0) begin
            in_min_d  = in_smp;
            in_max_d  = in_smp;
            out_min_d = out_smp;
            out_max_d = out_smp;
          end else begin
            in_min_d  = (in_smp  < in_min_q)  ? in_smp  : in_min_q;
            in_max_d  = (in_smp  > in_max_q)  ? in_smp  : in_max_q;
            out_min_d = (out_smp < out_min_q) ? out_smp : out_min_q;
            out_max_d = (out_smp > out_max_q) ? out_smp : out_max_q;
          end
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WINDOW - 1)) begin
            state_d = LOG;
            cnt_d   = '0;
          end
        end
      end
      LOG: begin
        in_pp_d     = in_pp_w;
        out_pp_d    = out_pp_w;
        gain_d      = gain_w;
        in_zero_d   = (in_pp_w == '0);
        res_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = continuous ? ACC : IDLE;
          cnt_d       = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d     = IDLE;
      cnt_d       = '0;
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      in_min_q    <= '0;
      in_max_q    <= '0;
      out_min_q   <= '0;
      out_max_q   <= '0;
      in_pp_q     <= '0;
      out_pp_q    <= '0;
      gain_q      <= '0;
      in_zero_q   <= 1'b0;
      res_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_min_q    <= in_min_d;
      in_max_q    <= in_max_d;
      out_min_q   <= out_min_d;
      out_max_q   <= out_max_d;
      in_pp_q     <= in_pp_d;
      out_pp_q    <= out_pp_d;
      gain_q      <= gain_d;
      in_zero_q   <= in_zero_d;
      res_valid_q <= res_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign res_valid = res_valid_q;
  assign in_pp     = in_pp_q;
  assign out_pp    = out_pp_q;
  assign gain_l2   = gain_q;
  assign in_zero   = in_zero_q;
  assign busy      = (state_q != IDLE);
  assign overrun   = overrun_q;

endmodule
